adder_share_arb: RTL and testbench

Round-robin arbiter sharing one registered ripple/carry adder (two-stage: operand register, sum register) among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake; the arbiter grants one per cycle, pipelines the operands through the shared adder and returns the WIDTH+1-bit sum tagged with the requester index. Sits between multiple arithmetic clients and the single adder datapath of the arithmetic benchmark set.

---
 rtl/adder_share_arb_if.sv | 27 ++
 rtl/adder_share_arb.sv | 122 ++++++++++++
 tb/tb_adder_share_arb.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arb_if.sv
// adder_share_arb_if: request/result bundle between arithmetic clients and
// the shared-adder arbiter. The client side uses the master modport, the
// arbiter uses the slave modport.
interface adder_share_arb_if #(
  parameter int WIDTH = 97,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [WIDTH:0]        res_sum;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_id, res_sum, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_id, res_sum, busy
  );
endinterface

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter in front of one two-stage registered
// adder (operand register, then sum register). One grant per cycle, results
// return two cycles after the transfer, tagged with the requester index.
// Optional build macro ADDER_SHARE_ARB_FIXED_PRIO_EN: removes the rotating
// pointer and grants with fixed priority (lowest index wins).
module adder_share_arb #(
  parameter int WIDTH = 97,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  adder_share_arb_if.slave    bus
);

  localparam logic [IDW:0]   NREQ_EXT = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  // Unpacked views of the flat operand buses, one entry per requester.
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_found;
  logic [IDW:0]    scan_idx;

  // Grant: first valid requester scanning upward from ptr with wrap-around.
  // Held at zero while reset is asserted so nothing transfers during reset.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr} + (IDW+1)'(k);
      if (scan_idx >= NREQ_EXT) begin
        scan_idx = scan_idx - NREQ_EXT;
      end
      if (!grant_found && rst_n && en && bus.req_valid[scan_idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[IDW-1:0];
      end
    end
    if (grant_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign bus.req_ready = grant;

`ifdef ADDER_SHARE_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDW-1:0] ptr_reg;

  // Pointer moves just past the requester that was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (grant_found) begin
      ptr_reg <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  assign ptr = ptr_reg;
`endif

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDW-1:0]   id1_reg;
  logic             v1_reg;

  // Stage 1: capture the granted operand pair; operands hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      id1_reg <= '0;
      v1_reg  <= 1'b0;
    end else begin
      v1_reg <= grant_found;
      if (grant_found) begin
        a_reg   <= a_arr[grant_idx];
        b_reg   <= b_arr[grant_idx];
        id1_reg <= grant_idx;
      end
    end
  end

  logic [WIDTH:0]   sum_reg;
  logic [IDW-1:0]   id2_reg;
  logic             v2_reg;

  // Stage 2: full-width sum with carry in the MSB, tag follows the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg <= '0;
      id2_reg <= '0;
      v2_reg  <= 1'b0;
    end else begin
      sum_reg <= {1'b0, a_reg} + {1'b0, b_reg};
      id2_reg <= id1_reg;
      v2_reg  <= v1_reg;
    end
  end

  assign bus.res_valid = v2_reg;
  assign bus.res_id    = id2_reg;
  assign bus.res_sum   = sum_reg;
  assign bus.busy      = v1_reg | v2_reg;

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed vectors with hand-computed expectations for
// the shared-adder arbiter. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
module tb_adder_share_arb;

  localparam int WIDTH = 97;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
`ifdef ADDER_SHARE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic en;

  int n_checks;
  int n_fail;

  adder_share_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  adder_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any mismatch.
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic set_req(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_valid[idx]               = 1'b1;
    bus.req_a[idx*WIDTH +: WIDTH]    = a;
    bus.req_b[idx*WIDTH +: WIDTH]    = b;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    en            = 1'b1;
    rst_n         = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [127:0] onehot(input int i);
    logic [127:0] v;
    v = 128'd1;
    return v << i;
  endfunction

  // Operand pattern for the multi-requester tests: a = 100*(i+1), b = i.
  function automatic logic [127:0] rr_sum(input int i);
    return 128'(100 * (i + 1) + i);
  endfunction

  logic [WIDTH-1:0] all_ones;
  logic [127:0]     carry_exp;
  int               g;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    all_ones = '1;
    // 2^98 - 2: bit 97 set, bits 96..1 set, bit 0 clear.
    carry_exp = '0;
    carry_exp[97:1] = '1;

    // ---- reset with every requester valid
    rst_n         = 1'b0;
    en            = 1'b1;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 128'(bus.req_ready), 128'd0);
    check("rst_res_valid", 128'(bus.res_valid), 128'd0);
    check("rst_res_sum", 128'(bus.res_sum), 128'd0);
    check("rst_res_id", 128'(bus.res_id), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_grant", 128'(bus.req_ready), onehot(0));

    // ---- single request from requester 2: 5 + 7
    do_reset();
    set_req(2, 97'd5, 97'd7);
    @(negedge clk);
    check("single_ready", 128'(bus.req_ready), FIXED ? onehot(2) : onehot(2));
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    check("single_n1_valid", 128'(bus.res_valid), 128'd0);
    check("single_n1_busy", 128'(bus.busy), 128'd1);
    @(negedge clk);
    check("single_n2_valid", 128'(bus.res_valid), 128'd1);
    check("single_n2_id", 128'(bus.res_id), 128'd2);
    check("single_n2_sum", 128'(bus.res_sum), 128'd12);
    @(negedge clk);
    check("single_n3_valid", 128'(bus.res_valid), 128'd0);
    check("single_n3_busy", 128'(bus.busy), 128'd0);

    // ---- carry out: (2^97-1) + (2^97-1)
    do_reset();
    set_req(1, all_ones, all_ones);
    @(negedge clk);
    check("carry_ready", 128'(bus.req_ready), onehot(1));
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("carry_valid", 128'(bus.res_valid), 128'd1);
    check("carry_id", 128'(bus.res_id), 128'd1);
    check("carry_sum", 128'(bus.res_sum), carry_exp);
    check("carry_msb", 128'(bus.res_sum[WIDTH]), 128'd1);

    // ---- round robin: all four valid for 8 cycles
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 97'(100 * (i + 1)), 97'(i));
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      g = FIXED ? 0 : (k % NREQ);
      check($sformatf("rr_ready_c%0d", k), 128'(bus.req_ready), (k < 8) ? onehot(g) : 128'd0);
      check($sformatf("rr_valid_c%0d", k), 128'(bus.res_valid), (k >= 2 && k < 10) ? 128'd1 : 128'd0);
      if (k >= 2 && k < 10) begin
        g = FIXED ? 0 : ((k - 2) % NREQ);
        check($sformatf("rr_id_c%0d", k), 128'(bus.res_id), 128'(g));
        check($sformatf("rr_sum_c%0d", k), 128'(bus.res_sum), rr_sum(g));
      end
      if (k == 7) begin
        @(posedge clk);
        #1 bus.req_valid = '0;
      end
    end

    // ---- en gating after grants to 0 and 1
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 97'(100 * (i + 1)), 97'(i));
    @(negedge clk);
    check("en_c0_ready", 128'(bus.req_ready), onehot(0));
    @(negedge clk);
    check("en_c1_ready", 128'(bus.req_ready), FIXED ? onehot(0) : onehot(1));
    @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    check("en_c2_ready", 128'(bus.req_ready), 128'd0);
    check("en_c2_valid", 128'(bus.res_valid), 128'd1);
    check("en_c2_id", 128'(bus.res_id), 128'd0);
    check("en_c2_busy", 128'(bus.busy), 128'd1);
    @(negedge clk);
    check("en_c3_ready", 128'(bus.req_ready), 128'd0);
    check("en_c3_valid", 128'(bus.res_valid), 128'd1);
    check("en_c3_id", 128'(bus.res_id), FIXED ? 128'd0 : 128'd1);
    check("en_c3_sum", 128'(bus.res_sum), FIXED ? rr_sum(0) : rr_sum(1));
    @(negedge clk);
    check("en_c4_valid", 128'(bus.res_valid), 128'd0);
    check("en_c4_busy", 128'(bus.busy), 128'd0);
    @(posedge clk);
    #1 en = 1'b1;
    @(negedge clk);
    check("en_resume_ready", 128'(bus.req_ready), FIXED ? onehot(0) : onehot(2));
    @(posedge clk);
    #1 bus.req_valid = '0;

    // ---- reset one cycle after a transfer to requester 1
    do_reset();
    set_req(1, 97'd1, 97'd1);
    @(negedge clk);
    check("mid_ready", 128'(bus.req_ready), onehot(1));
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 128'(bus.busy), 128'd0);
    check("mid_rst_valid", 128'(bus.res_valid), 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mid_after_valid_c%0d", k), 128'(bus.res_valid), 128'd0);
    end
    bus.req_valid = '1;
    #1;
    check("mid_ptr_zero", 128'(bus.req_ready), onehot(0));
    @(posedge clk);
    #1 bus.req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
